rio_link_rx_align_n: RTL and testbench

//  Parametrised RX comma aligner between GTP RX port (BYTES-wide, comma-detect only) and link RX logic.

---
 rtl/rio_link_rx_align_n.sv | 224 ++++++++++++++++++++++
 tb/tb_rio_link_rx_align_n.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rio_link_rx_align_n.sv
// RX comma aligner: finds the K28.5 byte lane in the raw GTP word and
// rotates the stream so the comma always lands on lane 0. A lock filter
// needs several commas on the same lane to acquire lock. Lock is dropped
// after repeated wrong-lane commas or after a long gap without an aligned comma.
module rio_link_rx_align_n #(
  parameter int         BYTES         = 2,
  parameter logic [7:0] COMMA_CHAR    = 8'hBC,
  parameter int         LOCK_CNT      = 3,
  parameter int         UNLOCK_CNT    = 3,
  parameter int         COMMA_TIMEOUT = 1024,
  localparam int        OFS_W         = (BYTES > 1) ? $clog2(BYTES) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*BYTES-1:0]   i_rx_data,
  input  logic [BYTES-1:0]     i_rx_isk,
  output logic [8*BYTES-1:0]   o_rx_data,
  output logic [BYTES-1:0]     o_rx_isk,
  output logic                 o_locked,
  output logic [OFS_W-1:0]     o_offset,
  output logic                 o_realign
);

  localparam int CNT_W = $clog2(LOCK_CNT + 1);
  localparam int ERR_W = $clog2(UNLOCK_CNT + 1);
  localparam int TMR_W = (COMMA_TIMEOUT > 0) ? $clog2(COMMA_TIMEOUT + 1) : 1;

  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(LOCK_CNT);
  localparam logic [ERR_W-1:0] ERR_LIM = ERR_W'(UNLOCK_CNT);
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(COMMA_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_MAX = {TMR_W{1'b1}};

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_next;
  logic [OFS_W-1:0]     r_cand;
  logic [OFS_W-1:0]     w_cand_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [CNT_W-1:0]     w_cnt_inc;
  logic [ERR_W-1:0]     r_err;
  logic [ERR_W-1:0]     w_err_next;
  logic [ERR_W-1:0]     w_err_inc;
  logic [TMR_W-1:0]     r_tmr;
  logic [TMR_W-1:0]     w_tmr_next;
  logic [TMR_W-1:0]     w_tmr_inc;
  logic [OFS_W-1:0]     r_offset;
  logic [OFS_W-1:0]     w_ofs_next;
  logic                 w_acquire;

  logic [8*BYTES-1:0]   r_prev_data;
  logic [BYTES-1:0]     r_prev_isk;
  logic [8*BYTES-1:0]   r_rx_data;
  logic [BYTES-1:0]     r_rx_isk;
  logic                 r_locked;
  logic                 r_realign;

  logic [16*BYTES-1:0]  w_cat_data;
  logic [2*BYTES-1:0]   w_cat_isk;
  logic [8*BYTES-1:0]   w_rot_data;
  logic [BYTES-1:0]     w_rot_isk;
  logic [BYTES-1:0]     w_comma;
  logic [OFS_W-1:0]     w_first;
  logic                 w_any;
  logic                 w_aligned;
  logic                 w_cand_hit;

  // Per-lane comma detection and lowest-lane priority pick.
  always_comb begin
    w_first = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_comma[k] = i_rx_isk[k] & (i_rx_data[8*k +: 8] == COMMA_CHAR);
    end
    for (int k = BYTES - 1; k >= 0; k--) begin
      if (w_comma[k]) begin
        w_first = OFS_W'(k);
      end else begin
        w_first = w_first;
      end
    end
    w_any      = |w_comma;
    w_aligned  = w_comma[r_offset];
    w_cand_hit = w_comma[r_cand];
  end

  // Rotate the {current, previous} word pair by the applied offset.
  always_comb begin
    w_cat_data = {i_rx_data, r_prev_data};
    w_cat_isk  = {i_rx_isk, r_prev_isk};
    for (int j = 0; j < BYTES; j++) begin
      w_rot_data[8*j +: 8] = w_cat_data[8*(j + int'(r_offset)) +: 8];
      w_rot_isk[j]         = w_cat_isk[j + int'(r_offset)];
    end
  end

  // Saturating increments for the lock filter counters.
  always_comb begin
    w_cnt_inc = (r_cnt == CNT_LIM) ? r_cnt : r_cnt + CNT_W'(1);
    w_err_inc = (r_err == ERR_LIM) ? r_err : r_err + ERR_W'(1);
    w_tmr_inc = (r_tmr == TMR_MAX) ? r_tmr : r_tmr + TMR_W'(1);
  end

  // Lock filter next-state: hunt for a lane, verify it, then police it.
  always_comb begin
    w_state_next = r_state;
    w_cand_next  = r_cand;
    w_cnt_next   = r_cnt;
    w_err_next   = r_err;
    w_tmr_next   = r_tmr;
    w_ofs_next   = r_offset;
    w_acquire    = 1'b0;
    case (r_state)
      ST_HUNT: begin
        if (w_any) begin
          w_cand_next = w_first;
          w_cnt_next  = CNT_W'(1);
          if (LOCK_CNT == 1) begin
            w_state_next = ST_LOCKED;
            w_ofs_next   = w_first;
            w_acquire    = 1'b1;
            w_err_next   = '0;
            w_tmr_next   = '0;
          end else begin
            w_state_next = ST_VERIFY;
          end
        end else begin
          w_state_next = ST_HUNT;
        end
      end
      ST_VERIFY: begin
        if (w_cand_hit) begin
          w_cnt_next = w_cnt_inc;
          if (w_cnt_inc == CNT_LIM) begin
            w_state_next = ST_LOCKED;
            w_ofs_next   = r_cand;
            w_acquire    = 1'b1;
            w_err_next   = '0;
            w_tmr_next   = '0;
          end else begin
            w_state_next = ST_VERIFY;
          end
        end else if (w_any) begin
          w_cand_next = w_first;
          w_cnt_next  = CNT_W'(1);
        end else begin
          w_state_next = ST_VERIFY;
        end
      end
      ST_LOCKED: begin
        if (w_aligned) begin
          // An aligned comma wins even if a wrong-lane comma shares the word.
          w_err_next = '0;
          w_tmr_next = '0;
        end else begin
          // Any word without an aligned comma advances the timeout.
          w_tmr_next = w_tmr_inc;
          if (w_any) begin
            w_err_next = w_err_inc;
          end else begin
            w_err_next = r_err;
          end
          if ((w_any && (w_err_inc == ERR_LIM)) ||
              ((COMMA_TIMEOUT != 0) && (w_tmr_inc == TMR_LIM))) begin
            w_state_next = ST_HUNT;
            w_cnt_next   = '0;
            w_err_next   = '0;
            w_tmr_next   = '0;
          end else begin
            w_state_next = ST_LOCKED;
          end
        end
      end
      default: begin
        w_state_next = ST_HUNT;
        w_cnt_next   = '0;
        w_err_next   = '0;
        w_tmr_next   = '0;
      end
    endcase
  end

  // State, counters, datapath pipe and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_HUNT;
      r_cand      <= '0;
      r_cnt       <= '0;
      r_err       <= '0;
      r_tmr       <= '0;
      r_offset    <= '0;
      r_prev_data <= {BYTES{COMMA_CHAR}};
      r_prev_isk  <= '1;
      r_rx_data   <= '0;
      r_rx_isk    <= '1;
      r_locked    <= 1'b0;
      r_realign   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cand      <= w_cand_next;
      r_cnt       <= w_cnt_next;
      r_err       <= w_err_next;
      r_tmr       <= w_tmr_next;
      r_offset    <= w_ofs_next;
      r_prev_data <= i_rx_data;
      r_prev_isk  <= i_rx_isk;
      r_rx_data   <= w_rot_data;
      r_rx_isk    <= w_rot_isk;
      r_locked    <= (w_state_next == ST_LOCKED);
      r_realign   <= w_acquire && (w_ofs_next != r_offset);
    end
  end

  assign o_rx_data = r_rx_data;
  assign o_rx_isk  = r_rx_isk;
  assign o_locked  = r_locked;
  assign o_offset  = r_offset;
  assign o_realign = r_realign;

endmodule

// File: tb/tb_rio_link_rx_align_n.sv
// Directed bench for the RX comma aligner: a 4-byte instance with a short
// timeout for lock/unlock/timeout behaviour, and a 2-byte single-comma-lock
// instance for the immediate-lock rotation case.
module tb_rio_link_rx_align_n;

  logic        clk;
  logic        a_rst;
  logic [31:0] a_rx_data_i;
  logic [3:0]  a_rx_isk_i;
  logic [31:0] a_rx_data;
  logic [3:0]  a_rx_isk;
  logic        a_locked;
  logic [1:0]  a_offset;
  logic        a_realign;

  logic        b_rst;
  logic [15:0] b_rx_data_i;
  logic [1:0]  b_rx_isk_i;
  logic [15:0] b_rx_data;
  logic [1:0]  b_rx_isk;
  logic        b_locked;
  logic [0:0]  b_offset;
  logic        b_realign;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] C_WORD = 32'h77BC2233;  // comma on lane 2
  localparam logic [3:0]  C_ISK  = 4'b0100;
  localparam logic [31:0] W_WORD = 32'h0000BC00;  // comma on lane 1
  localparam logic [3:0]  W_ISK  = 4'b0010;
  localparam logic [31:0] F_WORD = 32'hA5A5A5A5;  // plain data

  rio_link_rx_align_n #(
    .BYTES(4), .COMMA_CHAR(8'hBC), .LOCK_CNT(3), .UNLOCK_CNT(3), .COMMA_TIMEOUT(16)
  ) u_dut_a (
    .clk(clk), .rst(a_rst), .i_rx_data(a_rx_data_i), .i_rx_isk(a_rx_isk_i),
    .o_rx_data(a_rx_data), .o_rx_isk(a_rx_isk), .o_locked(a_locked),
    .o_offset(a_offset), .o_realign(a_realign)
  );

  rio_link_rx_align_n #(
    .BYTES(2), .COMMA_CHAR(8'hBC), .LOCK_CNT(1), .UNLOCK_CNT(3), .COMMA_TIMEOUT(1024)
  ) u_dut_b (
    .clk(clk), .rst(b_rst), .i_rx_data(b_rx_data_i), .i_rx_isk(b_rx_isk_i),
    .o_rx_data(b_rx_data), .o_rx_isk(b_rx_isk), .o_locked(b_locked),
    .o_offset(b_offset), .o_realign(b_realign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step_a(input logic [31:0] d, input logic [3:0] k);
    a_rx_data_i = d;
    a_rx_isk_i  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_a(input int n);
    for (int i = 0; i < n; i++) step_a(F_WORD, 4'b0000);
  endtask

  task automatic step_b(input logic [15:0] d, input logic [1:0] k);
    b_rx_data_i = d;
    b_rx_isk_i  = k;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    a_rst = 1'b1;
    for (int i = 0; i < 2; i++) step_a($urandom, 4'($urandom));
    checks++; if (a_rx_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected %h", a_rx_data, 32'h0); end
    checks++; if (a_rx_isk !== 4'hF) begin errors++; $display("FAIL reset_isk: got %h expected %h", a_rx_isk, 4'hF); end
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %b expected 0", a_locked); end
    checks++; if (a_offset !== 2'd0) begin errors++; $display("FAIL reset_offset: got %0d expected 0", a_offset); end
    checks++; if (a_realign !== 1'b0) begin errors++; $display("FAIL reset_realign: got %b expected 0", a_realign); end
    a_rst = 1'b0;
    // First word out after reset comes from the comma-filled previous-word pipe.
    step_a(32'h01020304, 4'b0000);
    checks++; if (a_rx_data !== 32'hBCBCBCBC) begin errors++; $display("FAIL reset_prev_data: got %h expected %h", a_rx_data, 32'hBCBCBCBC); end
    checks++; if (a_rx_isk !== 4'hF) begin errors++; $display("FAIL reset_prev_isk: got %h expected %h", a_rx_isk, 4'hF); end
  endtask

  task automatic test_lock_acquire;
    step_a(C_WORD, C_ISK);
    fill_a(7);
    step_a(C_WORD, C_ISK);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL acq_early_lock: got %b expected 0", a_locked); end
    fill_a(7);
    step_a(C_WORD, C_ISK);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL acq_locked: got %b expected 1", a_locked); end
    checks++; if (a_offset !== 2'd2) begin errors++; $display("FAIL acq_offset: got %0d expected 2", a_offset); end
    checks++; if (a_realign !== 1'b1) begin errors++; $display("FAIL acq_realign: got %b expected 1", a_realign); end
    step_a(32'h44332211, 4'b0000);
    checks++; if (a_rx_data !== 32'h221177BC) begin errors++; $display("FAIL acq_rot_data: got %h expected %h", a_rx_data, 32'h221177BC); end
    checks++; if (a_rx_isk !== 4'b0001) begin errors++; $display("FAIL acq_rot_isk: got %b expected %b", a_rx_isk, 4'b0001); end
    checks++; if (a_realign !== 1'b0) begin errors++; $display("FAIL acq_realign_pulse: got %b expected 0", a_realign); end
  endtask

  task automatic test_unlock_wrong_lane;
    step_a(W_WORD, W_ISK);
    fill_a(3);
    step_a(W_WORD, W_ISK);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL unlock_early: got %b expected 1", a_locked); end
    fill_a(3);
    step_a(W_WORD, W_ISK);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL unlock_locked: got %b expected 0", a_locked); end
    fill_a(2);
    checks++; if (a_offset !== 2'd2) begin errors++; $display("FAIL unlock_offset_hold: got %0d expected 2", a_offset); end
  endtask

  task automatic test_tolerance;
    // Relock on the same lane: no realign pulse.
    step_a(C_WORD, C_ISK);
    fill_a(3);
    step_a(C_WORD, C_ISK);
    fill_a(3);
    step_a(C_WORD, C_ISK);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL relock_locked: got %b expected 1", a_locked); end
    checks++; if (a_realign !== 1'b0) begin errors++; $display("FAIL relock_realign: got %b expected 0", a_realign); end
    for (int i = 0; i < 10; i++) begin
      step_a(W_WORD, W_ISK);
      fill_a(2);
      step_a(C_WORD, C_ISK);
      fill_a(1);
      checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL tol_iter%0d: got %b expected 1", i, a_locked); end
    end
    // Word with both aligned and wrong-lane comma counts as good.
    step_a(W_WORD, W_ISK);
    step_a(W_WORD, W_ISK);
    step_a(32'h00BCBC00, 4'b0110);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL tol_combo: got %b expected 1", a_locked); end
    step_a(W_WORD, W_ISK);
    step_a(W_WORD, W_ISK);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL tol_combo_reset_err: got %b expected 1", a_locked); end
  endtask

  task automatic test_timeout;
    step_a(C_WORD, C_ISK);
    fill_a(15);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL timeout_early: got %b expected 1", a_locked); end
    fill_a(1);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL timeout_drop: got %b expected 0", a_locked); end
    checks++; if (a_offset !== 2'd2) begin errors++; $display("FAIL timeout_offset: got %0d expected 2", a_offset); end
  endtask

  task automatic test_reset_in_verify;
    step_a(C_WORD, C_ISK);
    fill_a(1);
    step_a(C_WORD, C_ISK);
    a_rst = 1'b1;
    step_a(F_WORD, 4'b0000);
    a_rst = 1'b0;
    checks++; if (a_offset !== 2'd0) begin errors++; $display("FAIL rstv_offset: got %0d expected 0", a_offset); end
    step_a(C_WORD, C_ISK);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL rstv_no_partial: got %b expected 0", a_locked); end
    fill_a(1);
    step_a(C_WORD, C_ISK);
    fill_a(1);
    checks++; if (a_locked !== 1'b0) begin errors++; $display("FAIL rstv_second: got %b expected 0", a_locked); end
    step_a(C_WORD, C_ISK);
    checks++; if (a_locked !== 1'b1) begin errors++; $display("FAIL rstv_relock: got %b expected 1", a_locked); end
    checks++; if (a_realign !== 1'b1) begin errors++; $display("FAIL rstv_realign: got %b expected 1", a_realign); end
  endtask

  task automatic test_lock_cnt1;
    b_rst = 1'b1;
    step_b(16'h0000, 2'b00);
    step_b(16'h0000, 2'b00);
    b_rst = 1'b0;
    step_b(16'hBC12, 2'b10);
    checks++; if (b_offset !== 1'b1) begin errors++; $display("FAIL b_offset: got %0d expected 1", b_offset); end
    checks++; if (b_locked !== 1'b1) begin errors++; $display("FAIL b_locked: got %b expected 1", b_locked); end
    checks++; if (b_realign !== 1'b1) begin errors++; $display("FAIL b_realign: got %b expected 1", b_realign); end
    step_b(16'h3456, 2'b00);
    checks++; if (b_rx_data !== 16'h56BC) begin errors++; $display("FAIL b_rot_data: got %h expected %h", b_rx_data, 16'h56BC); end
    checks++; if (b_rx_isk !== 2'b01) begin errors++; $display("FAIL b_rot_isk: got %b expected %b", b_rx_isk, 2'b01); end
    checks++; if (b_realign !== 1'b0) begin errors++; $display("FAIL b_realign_pulse: got %b expected 0", b_realign); end
  endtask

  initial begin
    a_rst       = 1'b1;
    b_rst       = 1'b1;
    a_rx_data_i = 32'h0;
    a_rx_isk_i  = 4'h0;
    b_rx_data_i = 16'h0;
    b_rx_isk_i  = 2'b00;
    test_reset;
    test_lock_acquire;
    test_unlock_wrong_lane;
    test_tolerance;
    test_timeout;
    test_reset_in_verify;
    test_lock_cnt1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
